fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter RESET_VEC, default 32'h0000_0000: the fetch address after reset; it equals the reset value of the PC register.
REQ-002 Parameter TRAP_VEC, default 32'h0000_0100: the redirect target on trap.
REQ-003 clk  in  1  single clock; all state updates on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 pc_current  in  32  output of the PC register.
REQ-006 pc_next  out  32  D input of the PC register.
REQ-007 imem_req  out  1  instruction-memory request.
REQ-008 imem_addr  out  32  request address.
REQ-009 imem_ack  in  1  memory response valid, arriving 1 or more cycles after the request.
REQ-010 imem_rdata  in  32  instruction word, valid with imem_ack.
REQ-011 inst_valid  out  1  instruction available to decode.
REQ-012 inst_out  out  32  buffered instruction.
REQ-013 inst_pc  out  32  address of inst_out.
REQ-014 stall  in  1  decode not ready; while high, the held instruction is retained.
REQ-015 redirect_valid  in  1  branch/jump taken, 1-cycle pulse.
REQ-016 redirect_target  in  32  branch/jump target.
REQ-017 trap  in  1  exception pulse; redirects fetch to TRAP_VEC.

Function
REQ-018 The FSM SHALL have four states: BOOT, FETCH, HOLD and FLUSH.
REQ-019 BOOT SHALL move to FETCH unconditionally in the cycle after rst deasserts.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc_current.
REQ-021 In FETCH with imem_ack=1 and no redirect or trap:
- latch imem_rdata into inst_out and pc_current into inst_pc;
- set inst_valid;
- set pc_next = pc_current + 4 (modulo 2^32, with wrap from 32'hFFFF_FFFC to 0);
- go to HOLD if stall=1, else stay in FETCH.
REQ-022 In HOLD, imem_req SHALL be 0, inst_valid, inst_out and inst_pc SHALL remain stable, and pc_next SHALL equal pc_current; the FSM returns to FETCH when stall=0.
REQ-023 In every state, pc_next SHALL be selected with priority trap > redirect_valid > advance > hold; the selected value is visible as pc_current one cycle later.
REQ-024 A redirect target SHALL have bits [1:0] forced to 2'b00.
REQ-025 On trap or redirect in FETCH with imem_ack=0, the outstanding response SHALL be discarded by going to FLUSH.
REQ-026 In FLUSH, imem_req SHALL be 0; when imem_ack arrives, the data SHALL be dropped and the FSM goes to FETCH.
REQ-027 On trap or redirect in FETCH coinciding with imem_ack=1, the data SHALL be dropped and the FSM stays in FETCH at the new PC.
REQ-028 On trap or redirect in any state, inst_valid SHALL clear on the next edge.
REQ-029 A trap or redirect arriving in FLUSH SHALL update pc_next, and FLUSH still awaits exactly one ack.
REQ-030 In FETCH, inst_valid SHALL drop the cycle after an ack is consumed by decode (stall=0), unless a new ack arrives in that cycle.
REQ-031 imem_addr SHALL be held stable while imem_req=1 and no ack has arrived.

Reset
REQ-032 rst=1 SHALL force: state BOOT, imem_req=0, inst_valid=0, inst_out=32'h0000_0013 (NOP), inst_pc=RESET_VEC, pc_next=RESET_VEC.
REQ-033 Reset asserted mid-request SHALL abandon the request; the memory is reset concurrently, so no FLUSH is needed.

Structure
REQ-034 A shared package, riscv_pkg, SHALL hold the state enum, NOP_INSN, RESET_VEC, TRAP_VEC and the fetch width of 32.
REQ-035 The next-PC priority mux SHALL be a combinational sub-module, npc_sel; the FSM and instruction buffer stay in fetch_ctrl.

Verification
REQ-036 Reset then zero-latency acks with stall=0 -> imem_addr sequence 0, 4, 8, 12; inst_pc matches one cycle later.
REQ-037 stall=1 for 3 cycles after the ack at PC=8 -> imem_req=0, inst_pc=8 and inst_out unchanged for 3 cycles, then fetch at 12.
REQ-038 redirect_valid to 32'h0000_0042 while the request at 16 is pending, with ack after 2 cycles -> that ack is dropped, the next imem_addr is 32'h0000_0040, and inst_valid=0 in between.
REQ-039 trap and redirect in the same cycle -> pc_next=TRAP_VEC (32'h100).
REQ-040 PC=32'hFFFF_FFFC with ack -> next imem_addr=32'h0000_0000.
REQ-041 rst pulsed while in FLUSH -> state BOOT, inst_valid=0, and first fetch at RESET_VEC.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-stage definitions: FSM states, architectural constants and fetch width.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSN  = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_VEC = 32'h0000_0000;
  localparam logic [XLEN-1:0] TRAP_VEC  = 32'h0000_0100;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_e;
endpackage

// File: rtl/npc_sel.sv
// Next-PC priority mux: trap > redirect > sequential advance > hold.
module npc_sel #(
  parameter logic [31:0] TRAP_VEC = riscv_pkg::TRAP_VEC
) (
  input  logic        trap,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        advance,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next
);
  always_comb begin
    if (trap)                pc_next = TRAP_VEC;
    else if (redirect_valid) pc_next = {redirect_target[31:2], 2'b00};
    else if (advance)        pc_next = pc_current + 32'd4;
    else                     pc_next = pc_current;
  end
endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: request FSM, one-entry instruction buffer and
// next-PC drive for an external PC register.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VEC = riscv_pkg::RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = riscv_pkg::TRAP_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_current,
  output logic [31:0] pc_next,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap
);
  import riscv_pkg::*;

  fetch_state_e state, state_nxt;
  logic         kill;
  logic         advance;
  logic [31:0]  npc;

  assign kill      = trap | redirect_valid;
  assign advance   = (state == FETCH) && imem_ack;
  assign imem_addr = pc_current;

  npc_sel #(.TRAP_VEC(TRAP_VEC)) u_npc (
    .trap            (trap),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .advance         (advance),
    .pc_current      (pc_current),
    .pc_next         (npc)
  );

  // Reset drives the PC register D input directly so it loads RESET_VEC.
  assign pc_next = rst ? RESET_VEC : npc;

  always_ff @(posedge clk) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    case (state)
      BOOT:  state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        // A kill with the response still in flight must swallow that response.
        if (kill)                  state_nxt = imem_ack ? FETCH : FLUSH;
        else if (imem_ack && stall) state_nxt = HOLD;
      end
      HOLD:  if (kill || !stall) state_nxt = FETCH;
      FLUSH: if (imem_ack)       state_nxt = FETCH;
      default: state_nxt = BOOT;
    endcase
    if (rst) imem_req = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inst_valid <= 1'b0;
      inst_out   <= NOP_INSN;
      inst_pc    <= RESET_VEC;
    end else if (kill) begin
      inst_valid <= 1'b0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            inst_valid <= 1'b1;
            inst_out   <= imem_rdata;
            inst_pc    <= pc_current;
          end else if (!stall) begin
            inst_valid <= 1'b0;
          end
        end
        HOLD:    if (!stall) inst_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural PC register closing the loop.
module tb_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_current, pc_next;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        inst_valid;
  logic [31:0] inst_out, inst_pc;
  logic        stall, redirect_valid, trap;
  logic [31:0] redirect_target;

  int n_cmp = 0;
  int n_err = 0;

  fetch_ctrl #(.RESET_VEC(32'h0000_0000), .TRAP_VEC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .pc_current(pc_current), .pc_next(pc_next),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .inst_valid(inst_valid), .inst_out(inst_out),
    .inst_pc(inst_pc), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .trap(trap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) pc_current <= pc_next;

  task automatic drive(input logic a, input logic [31:0] d, input logic s,
                       input logic r, input logic [31:0] t, input logic tr);
    imem_ack = a; imem_rdata = d; stall = s;
    redirect_valid = r; redirect_target = t; trap = tr;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    repeat (2) @(negedge clk);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b exp=0", inst_valid); end
    n_cmp++; if (inst_out !== 32'h13) begin n_err++; $display("FAIL rst_inst got=%h exp=00000013", inst_out); end
    n_cmp++; if (inst_pc !== 32'h0) begin n_err++; $display("FAIL rst_pc got=%h exp=00000000", inst_pc); end
    n_cmp++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL rst_npc got=%h exp=00000000", pc_next); end
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req got=%b exp=0", imem_req); end
  endtask

  // Zero-latency acks at 0,4,8,12; ends at negedge with FETCH at 16.
  task automatic test_seq;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'(4*i)) begin
        n_err++; $display("FAIL seq_addr%0d got=%b/%h exp=1/%h", i, imem_req, imem_addr, 32'(4*i)); end
      if (i > 0) begin
        n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'(4*(i-1))) begin
          n_err++; $display("FAIL seq_ipc%0d got=%b/%h exp=1/%h", i, inst_valid, inst_pc, 32'(4*(i-1))); end
      end
      drive(1, 32'hA000_0000 + 32'(i), 0, 0, 32'h0, 0);
      #1;
      n_cmp++; if (pc_next !== 32'(4*i+4)) begin
        n_err++; $display("FAIL seq_npc%0d got=%h exp=%h", i, pc_next, 32'(4*i+4)); end
    end
    @(negedge clk);
    n_cmp++; if (inst_pc !== 32'hC || inst_out !== 32'hA000_0003 || imem_addr !== 32'h10) begin
      n_err++; $display("FAIL seq_end got=%h/%h/%h exp=0000000c/a0000003/00000010", inst_pc, inst_out, imem_addr); end
  endtask

  // Redirect coinciding with ack at 16: data dropped, fetch at 8 next cycle.
  task automatic test_redirect_ack;
    drive(1, 32'hDEAD_0010, 0, 1, 32'h8, 0);
    #1;
    n_cmp++; if (pc_next !== 32'h8) begin n_err++; $display("FAIL rda_npc got=%h exp=00000008", pc_next); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin
      n_err++; $display("FAIL rda_addr got=%b/%h exp=1/00000008", imem_req, imem_addr); end
    n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 32'hA000_0003) begin
      n_err++; $display("FAIL rda_drop got=%b/%h exp=0/a0000003", inst_valid, inst_out); end
  endtask

  task automatic test_stall;
    drive(1, 32'h5555_0008, 1, 0, 32'h0, 0);
    for (int h = 0; h < 3; h++) begin
      @(negedge clk);
      drive(0, 32'h0, (h < 2), 0, 32'h0, 0);
      #1;
      n_cmp++; if (imem_req !== 1'b0 || inst_valid !== 1'b1) begin
        n_err++; $display("FAIL hold_req%0d got=%b/%b exp=0/1", h, imem_req, inst_valid); end
      n_cmp++; if (inst_pc !== 32'h8 || inst_out !== 32'h5555_0008) begin
        n_err++; $display("FAIL hold_buf%0d got=%h/%h exp=00000008/55550008", h, inst_pc, inst_out); end
      n_cmp++; if (pc_next !== 32'hC) begin n_err++; $display("FAIL hold_npc%0d got=%h exp=0000000c", h, pc_next); end
    end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'hC || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL hold_exit got=%b/%h/%b exp=1/0000000c/0", imem_req, imem_addr, inst_valid); end
  endtask

  // Redirect to 0x42 while request at 16 is pending; ack two cycles later is dropped.
  task automatic test_redirect_pending;
    drive(1, 32'hC000_000C, 0, 0, 32'h0, 0);
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h10 || inst_valid !== 1'b1) begin
      n_err++; $display("FAIL rdp_pre got=%h/%b exp=00000010/1", imem_addr, inst_valid); end
    drive(0, 32'h0, 0, 1, 32'h42, 0);
    #1;
    n_cmp++; if (pc_next !== 32'h40) begin n_err++; $display("FAIL rdp_npc got=%h exp=00000040", pc_next); end
    for (int f = 0; f < 2; f++) begin
      @(negedge clk);
      drive((f == 1), 32'hBAD0_BAD0, 0, 0, 32'h0, 0);
      n_cmp++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        n_err++; $display("FAIL rdp_flush%0d got=%b/%b exp=0/0", f, imem_req, inst_valid); end
    end
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rdp_addr got=%b/%h/%b exp=1/00000040/0", imem_req, imem_addr, inst_valid); end
    n_cmp++; if (inst_out !== 32'hC000_000C) begin
      n_err++; $display("FAIL rdp_drop got=%h exp=c000000c", inst_out); end
  endtask

  task automatic test_trap_priority;
    drive(1, 32'h1111_1111, 0, 1, 32'h200, 1);
    #1;
    n_cmp++; if (pc_next !== 32'h100) begin n_err++; $display("FAIL trap_npc got=%h exp=00000100", pc_next); end
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL trap_addr got=%h/%b exp=00000100/0", imem_addr, inst_valid); end
  endtask

  task automatic test_wrap;
    drive(0, 32'h0, 0, 1, 32'hFFFF_FFFF, 0);
    #1;
    n_cmp++; if (pc_next !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_align got=%h exp=fffffffc", pc_next); end
    @(negedge clk);
    drive(1, 32'h0, 0, 0, 32'h0, 0);
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_top got=%h exp=fffffffc", imem_addr); end
    drive(1, 32'h7777_7777, 0, 0, 32'h0, 0);
    #1;
    n_cmp++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL wrap_npc got=%h exp=00000000", pc_next); end
    @(negedge clk);
    n_cmp++; if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_out !== 32'h7777_7777) begin
      n_err++; $display("FAIL wrap_next got=%h/%h/%h exp=00000000/fffffffc/77777777", imem_addr, inst_pc, inst_out); end
  endtask

  task automatic test_reset_in_flush;
    drive(0, 32'h0, 0, 1, 32'h20, 0);
    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 0);
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rf_flush got=%b exp=0", imem_req); end
    rst = 1'b1;
    #1;
    n_cmp++; if (pc_next !== 32'h0) begin n_err++; $display("FAIL rf_npc got=%h exp=00000000", pc_next); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin
      n_err++; $display("FAIL rf_boot got=%b/%b exp=0/0", imem_req, inst_valid); end
    n_cmp++; if (inst_out !== 32'h13 || inst_pc !== 32'h0) begin
      n_err++; $display("FAIL rf_buf got=%h/%h exp=00000013/00000000", inst_out, inst_pc); end
    @(negedge clk);
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++; $display("FAIL rf_fetch got=%b/%h exp=1/00000000", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset;
    test_seq;
    test_redirect_ack;
    test_stall;
    test_redirect_pending;
    test_trap_priority;
    test_wrap;
    test_reset_in_flush;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
